// File: rtl/jpeg_mcu_sched.sv
`default_nettype none
// ============================================================================
// jpeg_mcu_sched : shares one DCT pipeline between Y/Cb/Cr in MCU block order.
// Optional stats port enabled by JPEG_MCU_SCHED_STATS_EN.   Revision: 1.0
// ============================================================================
module jpeg_mcu_sched #(
    parameter int  DATA_WIDTH    = 8,
    parameter int  MAX_Y_PER_MCU = 4,
    localparam int TDATA_W       = ((DATA_WIDTH + 7) / 8) * 8,
    localparam int TSTRB_W       = TDATA_W / 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               cfg_420_i,

    input  logic [TDATA_W-1:0] y_tdata,
    input  logic               y_tvalid,
    output logic               y_tready,
    input  logic               y_tuser,
    input  logic               y_tlast,

    input  logic [TDATA_W-1:0] cb_tdata,
    input  logic               cb_tvalid,
    output logic               cb_tready,
    input  logic               cb_tuser,
    input  logic               cb_tlast,

    input  logic [TDATA_W-1:0] cr_tdata,
    input  logic               cr_tvalid,
    output logic               cr_tready,
    input  logic               cr_tuser,
    input  logic               cr_tlast,

    output logic [TDATA_W-1:0] blk_tdata,
    output logic [TSTRB_W-1:0] blk_tstrb,
    output logic [TSTRB_W-1:0] blk_tkeep,
    output logic               blk_tvalid,
    input  logic               blk_tready,
    output logic               blk_tuser,
    output logic               blk_tlast,

    output logic [1:0]         comp_o,
`ifdef JPEG_MCU_SCHED_STATS_EN
    output logic [15:0]        blk_cnt_o,
`endif
    output logic               err_o
);

    localparam logic [1:0] Y_LAST = 2'(MAX_Y_PER_MCU - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        Y_BLK  = 2'd1,
        CB_BLK = 2'd2,
        CR_BLK = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [5:0]           beat_cnt;
    logic [1:0]           y_cnt;
    logic                 mode_q;
    logic                 first_q;
    logic                 pend_last;
    logic                 err_q;

    logic                 out_vld;
    logic [TDATA_W-1:0]   out_data;
    logic [1:0]           out_comp;
    logic                 out_user;
    logic                 out_last;

    logic                 slot_free;
    logic                 src_valid;
    logic [TDATA_W-1:0]   src_data;
    logic                 src_user;
    logic                 src_last;
    logic [1:0]           src_comp;
    logic                 acc;
    logic                 blk_end;
    logic                 frame_start;
    logic                 drop;
    logic                 frame_err;

    assign slot_free = !out_vld || blk_tready;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        y_tready    = 1'b0;
        cb_tready   = 1'b0;
        cr_tready   = 1'b0;
        src_valid   = 1'b0;
        src_data    = y_tdata;
        src_user    = y_tuser;
        src_last    = y_tlast;
        src_comp    = 2'd0;
        frame_start = 1'b0;
        drop        = 1'b0;

        case (state)
            IDLE: begin
                // The frame-start beat is held back here and taken in Y_BLK.
                frame_start = y_tvalid && y_tuser;
                drop        = y_tvalid && !y_tuser;
                y_tready    = !frame_start;
                if (frame_start) begin
                    state_nxt = Y_BLK;
                end
            end
            Y_BLK: begin
                y_tready  = slot_free;
                src_valid = y_tvalid;
            end
            CB_BLK: begin
                cb_tready = slot_free;
                src_valid = cb_tvalid;
                src_data  = cb_tdata;
                src_user  = cb_tuser;
                src_last  = cb_tlast;
                src_comp  = 2'd1;
            end
            CR_BLK: begin
                cr_tready = slot_free;
                src_valid = cr_tvalid;
                src_data  = cr_tdata;
                src_user  = cr_tuser;
                src_last  = cr_tlast;
                src_comp  = 2'd2;
            end
            default: state_nxt = IDLE;
        endcase

        acc     = src_valid && slot_free;
        blk_end = acc && (beat_cnt == 6'd63);

        if (blk_end) begin
            case (state)
                Y_BLK:   if (!mode_q || (y_cnt == Y_LAST)) state_nxt = CB_BLK;
                CB_BLK:  state_nxt = CR_BLK;
                CR_BLK:  state_nxt = src_last ? IDLE : Y_BLK;
                default: state_nxt = IDLE;
            endcase
        end

        if (!rst_n_i) begin
            y_tready  = 1'b0;
            cb_tready = 1'b0;
            cr_tready = 1'b0;
        end
    end

    assign frame_err = acc && ((src_last && (beat_cnt != 6'd63)) ||
                               (src_user && !first_q) ||
                               (blk_end && (state == CR_BLK) && pend_last && !src_last));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            beat_cnt  <= 6'd0;
            y_cnt     <= 2'd0;
            mode_q    <= 1'b0;
            first_q   <= 1'b0;
            pend_last <= 1'b0;
            err_q     <= 1'b0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_comp  <= 2'd0;
            out_user  <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (frame_start) begin
                mode_q    <= cfg_420_i;
                first_q   <= 1'b1;
                pend_last <= 1'b0;
            end

            if (acc) begin
                beat_cnt <= beat_cnt + 6'd1;
                first_q  <= 1'b0;
                out_vld  <= 1'b1;
                out_data <= src_data;
                out_comp <= src_comp;
                out_user <= first_q;
                out_last <= blk_end && (state == CR_BLK) && src_last;
            end else if (blk_tready) begin
                out_vld  <= 1'b0;
            end

            if (blk_end && (state == Y_BLK)) begin
                y_cnt <= (state_nxt == Y_BLK) ? y_cnt + 2'd1 : 2'd0;
            end

            // Y/Cb end-of-frame must be matched by Cr end-of-frame in the same MCU.
            if (blk_end && (state == CR_BLK)) begin
                pend_last <= 1'b0;
            end else if (blk_end && src_last) begin
                pend_last <= 1'b1;
            end

            if (drop || frame_err) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef JPEG_MCU_SCHED_STATS_EN
    logic [15:0] stat_cnt;
    logic [15:0] stat_inc;

    assign stat_inc = (stat_cnt == 16'hFFFF) ? stat_cnt : stat_cnt + 16'd1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stat_cnt  <= 16'd0;
            blk_cnt_o <= 16'd0;
        end else if (frame_start) begin
            stat_cnt <= 16'd0;
        end else if (blk_end) begin
            stat_cnt <= stat_inc;
            if ((state == CR_BLK) && src_last) begin
                blk_cnt_o <= stat_inc;
            end
        end
    end
`endif

    assign blk_tdata  = out_data;
    assign blk_tstrb  = '1;
    assign blk_tkeep  = '1;
    assign blk_tvalid = out_vld;
    assign blk_tuser  = out_user;
    assign blk_tlast  = out_last;
    assign comp_o     = out_comp;
    assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_mcu_sched.sv
`default_nettype none
// ============================================================================
// tb_jpeg_mcu_sched : directed self-checking bench for jpeg_mcu_sched.
// Revision: 1.0
// ============================================================================
module tb_jpeg_mcu_sched;

    localparam int LIMIT = 200;

    logic       clk_i;
    logic       rst_n_i;
    logic       cfg_420_i;
    logic [7:0] y_tdata, cb_tdata, cr_tdata;
    logic       y_tvalid, cb_tvalid, cr_tvalid;
    logic       y_tready, cb_tready, cr_tready;
    logic       y_tuser, cb_tuser, cr_tuser;
    logic       y_tlast, cb_tlast, cr_tlast;
    logic [7:0] blk_tdata;
    logic       blk_tstrb, blk_tkeep;
    logic       blk_tvalid, blk_tready, blk_tuser, blk_tlast;
    logic [1:0] comp_o;
    logic       err_o;
`ifdef JPEG_MCU_SCHED_STATS_EN
    logic [15:0] blk_cnt_o;
`endif

    jpeg_mcu_sched dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .cfg_420_i  (cfg_420_i),
        .y_tdata    (y_tdata),
        .y_tvalid   (y_tvalid),
        .y_tready   (y_tready),
        .y_tuser    (y_tuser),
        .y_tlast    (y_tlast),
        .cb_tdata   (cb_tdata),
        .cb_tvalid  (cb_tvalid),
        .cb_tready  (cb_tready),
        .cb_tuser   (cb_tuser),
        .cb_tlast   (cb_tlast),
        .cr_tdata   (cr_tdata),
        .cr_tvalid  (cr_tvalid),
        .cr_tready  (cr_tready),
        .cr_tuser   (cr_tuser),
        .cr_tlast   (cr_tlast),
        .blk_tdata  (blk_tdata),
        .blk_tstrb  (blk_tstrb),
        .blk_tkeep  (blk_tkeep),
        .blk_tvalid (blk_tvalid),
        .blk_tready (blk_tready),
        .blk_tuser  (blk_tuser),
        .blk_tlast  (blk_tlast),
        .comp_o     (comp_o),
`ifdef JPEG_MCU_SCHED_STATS_EN
        .blk_cnt_o  (blk_cnt_o),
`endif
        .err_o      (err_o)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] c;
        logic       u;
        logic       l;
    } beat_t;

    beat_t got[$];
    beat_t exp_q[$];
    beat_t mon_cur, mon_prev;
    bit    prev_stall;

    int checks, fails, timeouts;
    int stall_bad, stall_seen;
    int cyc;
    int first_hs_cyc, first_vld_cyc;
    bit track_first, bp_en;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_i);
            cyc = cyc + 1;
        end
    end

    // Downstream ready changes just after posedge so it is stable at negedge.
    initial begin
        blk_tready = 1'b1;
        forever begin
            @(posedge clk_i);
            #2;
            blk_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        prev_stall = 1'b0;
        mon_prev   = '0;
        forever begin
            @(negedge clk_i);
            mon_cur = {blk_tdata, comp_o, blk_tuser, blk_tlast};
            if (rst_n_i === 1'b1) begin
                if (prev_stall) begin
                    stall_seen++;
                    if (blk_tvalid !== 1'b1 || mon_cur !== mon_prev) stall_bad++;
                end
                if (blk_tvalid === 1'b1 && blk_tready === 1'b1) got.push_back(mon_cur);
                if (blk_tvalid === 1'b1 && track_first && first_vld_cyc < 0) first_vld_cyc = cyc;
                prev_stall = (blk_tvalid === 1'b1) && (blk_tready === 1'b0);
            end else begin
                prev_stall = 1'b0;
            end
            mon_prev = mon_cur;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic send_beat(input int comp, input logic [7:0] d, input logic u, input logic l);
        int   n;
        logic hs;
        if (timeouts != 0) return;
        case (comp)
            0: begin y_tdata = d; y_tuser = u; y_tlast = l; y_tvalid = 1'b1; end
            1: begin cb_tdata = d; cb_tuser = u; cb_tlast = l; cb_tvalid = 1'b1; end
            default: begin cr_tdata = d; cr_tuser = u; cr_tlast = l; cr_tvalid = 1'b1; end
        endcase
        n  = 0;
        hs = 1'b0;
        while (hs !== 1'b1 && n < LIMIT) begin
            #1;
            hs = (comp == 0) ? y_tready : (comp == 1) ? cb_tready : cr_tready;
            if (hs === 1'b1 && track_first && first_hs_cyc < 0) first_hs_cyc = cyc;
            @(posedge clk_i);
            @(negedge clk_i);
            n++;
        end
        if (hs !== 1'b1) timeouts++;
    endtask

    task automatic drop_valid(input int comp);
        case (comp)
            0: y_tvalid = 1'b0;
            1: cb_tvalid = 1'b0;
            default: cr_tvalid = 1'b0;
        endcase
    endtask

    // Beats lo..hi-1 of a block; sample value = comp*64 + beat index.
    task automatic send_block(input int comp, input bit first, input int tl_beat,
                              input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            logic [7:0] d;
            logic       u, l;
            d = 8'(comp * 64 + i);
            u = first && (i == 0);
            l = (i == tl_beat);
            exp_q.push_back({d, 2'(comp), u, (comp == 2) && l && (i == 63)});
            send_beat(comp, d, u, l);
        end
        drop_valid(comp);
    endtask

    task automatic frame(input bit m420, input int nmcu);
        int ny;
        cfg_420_i = m420;
        ny = m420 ? 4 : 1;
        for (int m = 0; m < nmcu; m++) begin
            bit lastm;
            lastm = (m == nmcu - 1);
            for (int k = 0; k < ny; k++)
                send_block(0, (m == 0) && (k == 0), (lastm && k == ny - 1) ? 63 : -1, 0, 64);
            send_block(1, 1'b0, lastm ? 63 : -1, 0, 64);
            send_block(2, 1'b0, lastm ? 63 : -1, 0, 64);
        end
    endtask

    task automatic wait_out(input string tag, input int n);
        int w;
        w = 0;
        while (got.size() < n && w < 4000) begin
            @(negedge clk_i);
            w++;
        end
        repeat (4) @(negedge clk_i);
        chk(tag, 64'(got.size()), 64'(n));
    endtask

    task automatic cmp_seq(input string tag);
        int bad, first_bad;
        bad       = 0;
        first_bad = -1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (first_bad >= 0)
            $display("first differing beat %0d: got %h want %h", first_bad,
                     got[first_bad], exp_q[first_bad]);
        chk(tag, 64'(bad), 64'd0);
    endtask

    task automatic clear_q();
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        checks = 0; fails = 0; timeouts = 0;
        stall_bad = 0; stall_seen = 0;
        first_hs_cyc = -1; first_vld_cyc = -1;
        track_first = 1'b0; bp_en = 1'b0;
        rst_n_i = 1'b0; cfg_420_i = 1'b0;
        y_tdata = 8'd0; cb_tdata = 8'd0; cr_tdata = 8'd0;
        y_tuser = 1'b0; cb_tuser = 1'b0; cr_tuser = 1'b0;
        y_tlast = 1'b0; cb_tlast = 1'b0; cr_tlast = 1'b0;
        y_tvalid = 1'b1; cb_tvalid = 1'b1; cr_tvalid = 1'b1;

        // Reset state, with every source offering data.
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_y_tready", 64'(y_tready), 64'd0);
        chk("rst_cb_tready", 64'(cb_tready), 64'd0);
        chk("rst_cr_tready", 64'(cr_tready), 64'd0);
        @(negedge clk_i);
        y_tvalid = 1'b0; cb_tvalid = 1'b0; cr_tvalid = 1'b0;
        rst_n_i = 1'b1;
        #1;
        chk("rst_tvalid", 64'(blk_tvalid), 64'd0);
        chk("rst_tdata", 64'(blk_tdata), 64'd0);
        chk("rst_tuser_tlast", 64'({blk_tuser, blk_tlast}), 64'd0);
        chk("rst_comp", 64'(comp_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("idle_drain_ready", 64'({y_tready, cb_tready, cr_tready}), 64'b100);
        chk("tstrb_tkeep", 64'({blk_tstrb, blk_tkeep}), 64'b11);

        // 4:4:4, one MCU, no backpressure.
        @(negedge clk_i);
        clear_q();
        track_first = 1'b1;
        frame(1'b0, 1);
        track_first = 1'b0;
        wait_out("f444_count", 192);
        cmp_seq("f444_seq");
        chk("f444_latency", 64'(first_vld_cyc - first_hs_cyc), 64'd1);
        chk("f444_err", 64'(err_o), 64'd0);

        // 4:2:0, two MCUs.
        clear_q();
        frame(1'b1, 2);
        wait_out("f420_count", 768);
        cmp_seq("f420_seq");
        chk("f420_err", 64'(err_o), 64'd0);
`ifdef JPEG_MCU_SCHED_STATS_EN
        chk("f420_blk_cnt", 64'(blk_cnt_o), 64'd12);
`endif

        // Random downstream backpressure.
        clear_q();
        stall_bad = 0; stall_seen = 0;
        bp_en = 1'b1;
        frame(1'b0, 1);
        wait_out("bp_count", 192);
        bp_en = 1'b0;
        cmp_seq("bp_seq");
        chk("bp_stall_stable", 64'(stall_bad), 64'd0);
        chk("bp_stalls_seen", 64'(stall_seen > 0), 64'd1);

        // Cb tlast at beat 40.
        @(negedge clk_i);
        clear_q();
        cfg_420_i = 1'b0;
        send_block(0, 1'b1, 63, 0, 64);
        send_block(1, 1'b0, 40, 0, 40);
        chk("ferr_before", 64'(err_o), 64'd0);
        send_block(1, 1'b0, 40, 40, 41);
        chk("ferr_next_cycle", 64'(err_o), 64'd1);
        send_block(1, 1'b0, 40, 41, 64);
        send_block(2, 1'b0, 63, 0, 64);
        wait_out("ferr_count", 192);
        cmp_seq("ferr_seq");
        chk("ferr_sticky", 64'(err_o), 64'd1);
        @(negedge clk_i);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        chk("ferr_reset_clears", 64'(err_o), 64'd0);

        // Three non-tuser Y beats drained in IDLE, then a normal frame.
        @(negedge clk_i);
        clear_q();
        cfg_420_i = 1'b0;
        repeat (3) send_beat(0, 8'hEE, 1'b0, 1'b0);
        y_tvalid = 1'b0;
        chk("drain_err", 64'(err_o), 64'd1);
        frame(1'b0, 1);
        wait_out("drain_count", 192);
        cmp_seq("drain_seq");
        chk("drain_err_sticky", 64'(err_o), 64'd1);

        // Reset for one cycle at Cb beat 20.
        clear_q();
        send_block(0, 1'b1, 63, 0, 64);
        send_block(1, 1'b0, -1, 0, 20);
        cb_tdata  = 8'd84;
        cb_tvalid = 1'b1;
        rst_n_i   = 1'b0;
        #1;
        chk("mid_rst_ready", 64'({y_tready, cb_tready, cr_tready}), 64'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i   = 1'b1;
        cb_tvalid = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(blk_tvalid), 64'd0);
        chk("mid_rst_err", 64'(err_o), 64'd0);
        chk("mid_rst_idle", 64'({y_tready, cb_tready, cr_tready}), 64'b100);

        @(negedge clk_i);
        clear_q();
        frame(1'b0, 1);
        wait_out("recover_count", 192);
        cmp_seq("recover_seq");
        chk("recover_err", 64'(err_o), 64'd0);

        chk("handshake_timeouts", 64'(timeouts), 64'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jpeg_mcu_sched.md
Name: jpeg_mcu_sched

Overview:
- Block-granular scheduler that shares one DCT / zig-zag / quantiser pipeline between three component streams (Y, Cb, Cr).
- Sits between the colour-conversion / blocking stage and the DCT input.
- Forwards whole 64-sample blocks in JPEG MCU order: 4:4:4 = Y,Cb,Cr; 4:2:0 = Y,Y,Y,Y,Cb,Cr.
- Tags each beat with its component id and regenerates frame tuser/tlast for the shared pipeline.

Parameters:
- DATA_WIDTH, 8, significant sample bits per beat; tdata width is DATA_WIDTH rounded up to a multiple of 8.
- MAX_Y_PER_MCU, 4, Y blocks per MCU in 4:2:0 mode; legal values 2 or 4.

Ports:
- clk_i, input, 1, clock.
- rst_n_i, input, 1, synchronous active-low reset.
- cfg_420_i, input, 1, 1 = 4:2:0 ordering, 0 = 4:4:4; sampled only on frame start.
- y_i, axi4_stream_if.slave, –, luma blocks; tuser on first beat of frame, tlast on last beat of frame.
- cb_i, axi4_stream_if.slave, –, Cb blocks; same framing.
- cr_i, axi4_stream_if.slave, –, Cr blocks; same framing.
- blk_o, axi4_stream_if.master, –, scheduled blocks to the DCT.
- comp_o, output, 2, component of the current blk_o beat: 0 = Y, 1 = Cb, 2 = Cr; qualified by blk_o.tvalid.
- err_o, output, 1, sticky framing error; cleared only by reset.

Behaviour:
- Reset: synchronous, active-low, applies on any clock edge with rst_n_i = 0 including mid-block; partially forwarded block is abandoned. Reset values:
  - FSM = IDLE; beat_cnt = 0; y_cnt = 0.
  - blk_o.tvalid, tlast, tuser = 0; tdata = 0; comp_o = 0; err_o = 0.
  - y_i, cb_i, cr_i tready = 0.
- Output stage is a single register slice: 1 cycle latency, full throughput.
  - Selected source's tready = !out_vld_q || blk_o.tready.
  - Non-selected sources' tready = 0.
  - blk_o holds tdata, comp_o, tuser and tlast stable while tvalid && !tready.
  - tstrb and tkeep are all ones.
- FSM states: IDLE, Y_BLK, CB_BLK, CR_BLK.
- IDLE:
  - y_i.tready = 1 (drain mode); cb_i and cr_i tready = 0.
  - A Y beat with tuser = 0 is dropped and sets err_o.
  - A Y beat with tuser = 1 is not consumed in IDLE; the FSM latches cfg_420_i into mode_q and moves to Y_BLK. That beat is accepted as beat 0 of Y_BLK and forwarded with blk_o.tuser = 1.
- Each block state accepts exactly 64 beats; beat_cnt is 6-bit and wraps 63 → 0 on the 64th handshake.
- Y_BLK at beat 63:
  - y_cnt increments.
  - Go to CB_BLK if mode_q = 0, or if mode_q = 1 and y_cnt = MAX_Y_PER_MCU-1; otherwise stay in Y_BLK.
  - y_cnt clears on leaving Y_BLK.
- CB_BLK at beat 63 → CR_BLK.
- CR_BLK at beat 63:
  - cr_i.tlast = 1 → IDLE, and blk_o.tlast = 1 on that beat (end of frame).
  - cr_i.tlast = 0 → Y_BLK (next MCU).
- blk_o.tlast is driven only from Cr's final beat. Y/Cb tlast are checked, not forwarded.
- Framing checks, each sets err_o without altering sequencing:
  - any source tlast on a beat with beat_cnt != 63;
  - tuser = 1 on any accepted beat other than the frame's first Y beat;
  - Y or Cb tlast at beat 63 without Cr tlast at the end of the same MCU.
- Simultaneous events: blk_o.tready low while the source is valid stalls everything; beat_cnt and the FSM advance only on source handshakes.
- cfg_420_i changes mid-frame are ignored until the next IDLE exit.

Optional Feature:
- Macro JPEG_MCU_SCHED_STATS_EN.
- Defined:
  - Adds output blk_cnt_o [15:0]: count of blocks forwarded in the last completed frame, latched on the frame-final tlast handshake.
  - Internal counter resets to 0 at frame start and saturates at 16'hFFFF.
  - blk_cnt_o resets to 0.
- Undefined: no port, no counter; behaviour otherwise identical.

Test Plan:
- 4:4:4, one MCU frame: Y/Cb/Cr each 64 beats, blk_o.tready = 1 → 192 beats; comp_o sequence 0×64, 1×64, 2×64; tuser only on beat 0; tlast only on beat 191; first output one cycle after first Y handshake.
- 4:2:0, two MCUs (cfg_420_i = 1): 8 Y, 2 Cb, 2 Cr blocks → order Y,Y,Y,Y,Cb,Cr repeated twice; 768 beats; tlast on beat 767; with stats enabled, blk_cnt_o = 12.
- Backpressure: blk_o.tready toggled 1,0,0,1 randomly → tdata/comp_o stable during stalls; no beat lost or duplicated; sample values 0..63 per block arrive in order.
- Framing error: Cb tlast asserted at beat 40 → err_o = 1 from the next cycle and stays 1; sequencing still advances at beat 63.
- IDLE drain: three Y beats without tuser before a tuser beat → those three are consumed and not forwarded, err_o = 1; frame then proceeds normally.
- Reset mid-block: rst_n_i low for one cycle at Cb beat 20 → next cycle blk_o.tvalid = 0, state IDLE, err_o = 0, all slave tready = 0 during reset.
